// File: rtl/cim_pkg.sv
// Shared definitions for the GeMM CIM macro driver.
//   cim_state_e : driver FSM states (also visible on the debug port)
//   cim_op_e    : command opcodes carried on cmd_op
//   N_BANKS, MAX_STEPS, MAX_WORDS, CIM_STEP_BYTES, WORD_BYTES : geometry
//   len_ok()    : command length legality check
package cim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLR   = 3'd2,
    ST_MAC   = 3'd3,
    ST_DRAIN = 3'd4,
    ST_READ  = 3'd5
  } cim_state_e;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_MAC  = 1'b1
  } cim_op_e;

  localparam int unsigned N_BANKS        = 8;
  localparam int unsigned MAX_STEPS      = 16;   // 128-byte bank window / 8 bytes per step
  localparam int unsigned MAX_WORDS      = 256;  // 1024-byte array / 4 bytes per word
  localparam int unsigned CIM_STEP_BYTES = 8;
  localparam int unsigned WORD_BYTES     = 4;

  // A command length is legal when it is non-zero and within its op limit.
  function automatic logic len_ok(input logic op, input logic [8:0] len);
    logic [31:0] len_w;
    len_w = {23'b0, len};
    if (len_w == 32'd0) return 1'b0;
    if (op == OP_MAC) return (len_w <= MAX_STEPS);
    return (len_w <= MAX_WORDS);
  endfunction

endpackage

// File: rtl/cim_macro_driver.sv
// Initiator-side sequencer for the 8-bank GeMM CIM macro.
// Accepts LOAD (write weight words) and MAC (clear, stream input vectors,
// read back the 8 bank results) commands and owns every macro control pin.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op/cmd_base/cmd_len payload
//   cmd_err               one-cycle pulse when a command is rejected
//   in_valid/in_ready     input word stream (weights or 8x4-bit vectors), in_data
//   out_valid/out_ready   result stream, out_data (sign-extended bank result), out_last
//   busy                  high whenever the FSM is not idle
//   cim_*                 registered macro controls, address and write data
//   cim_rdata             macro output, combinational from cim_oreg
//   dbg_state             current FSM state
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where both valid and ready are high; valid never waits on ready.
module cim_macro_driver
  import cim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_op,
  input  logic [31:0] cmd_base,
  input  logic [8:0]  cmd_len,
  output logic        cmd_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        cim_cs,
  output logic        cim_we,
  output logic        cim_cime,
  output logic        cim_psum_e,
  output logic        cim_rst_oreg,
  output logic [3:0]  cim_oreg,
  output logic [31:0] cim_addr,
  output logic [31:0] cim_wdata,
  input  logic [31:0] cim_rdata,
  output cim_state_e  dbg_state
);

  localparam logic [3:0] LAST_BANK = 4'(N_BANKS - 1);

  cim_state_e  state_q;
  logic [31:0] base_q;
  logic [8:0]  len_q;
  logic [8:0]  cnt_q;
  logic        out_valid_q;
  logic        cmd_err_q;
  logic        cs_q, we_q, cime_q, psum_q, rst_oreg_q;
  logic [3:0]  oreg_q;
  logic [31:0] addr_q, wdata_q;

  logic        in_fire;
  logic        out_fire;
  logic        last_beat;
  logic [31:0] load_addr_d;
  logic [31:0] step_addr_d;

  assign cmd_ready = (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD) || (state_q == ST_MAC);
  assign busy      = (state_q != ST_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign last_beat = ((cnt_q + 9'd1) == len_q);

  // Address arithmetic is plain 32-bit and wraps; the macro only looks at
  // the low address bits, so no range checking is done here.
  assign load_addr_d = base_q + 32'(cnt_q) * WORD_BYTES;
  assign step_addr_d = base_q + 32'(cnt_q) * CIM_STEP_BYTES;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      cime_q      <= 1'b0;
      psum_q      <= 1'b0;
      rst_oreg_q  <= 1'b0;
      oreg_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      // Single-cycle strobes default low; every state re-asserts what it needs.
      cs_q       <= 1'b0;
      we_q       <= 1'b0;
      psum_q     <= 1'b0;
      rst_oreg_q <= 1'b0;
      cmd_err_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          cime_q      <= 1'b0;
          oreg_q      <= '0;
          out_valid_q <= 1'b0;
          if (cmd_valid) begin
            base_q <= cmd_base;
            len_q  <= cmd_len;
            cnt_q  <= '0;
            if (!len_ok(cmd_op, cmd_len)) begin
              cmd_err_q <= 1'b1;
            end else if (cmd_op == OP_MAC) begin
              state_q <= ST_CLR;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end

        ST_LOAD: begin
          cime_q <= 1'b0;
          if (in_fire) begin
            cs_q    <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= load_addr_d;
            wdata_q <= in_data;
            cnt_q   <= cnt_q + 9'd1;
            if (last_beat) state_q <= ST_IDLE;
          end
        end

        // Clear the accumulators before the first accumulate step.
        ST_CLR: begin
          cs_q       <= 1'b1;
          cime_q     <= 1'b1;
          rst_oreg_q <= 1'b1;
          state_q    <= ST_MAC;
        end

        ST_MAC: begin
          cime_q <= 1'b1;
          if (in_fire) begin
            cs_q    <= 1'b1;
            psum_q  <= 1'b1;
            addr_q  <= step_addr_d;
            wdata_q <= in_data;
            cnt_q   <= cnt_q + 9'd1;
            if (last_beat) state_q <= ST_DRAIN;
          end
        end

        // The last accumulate bus cycle is on the pins now; its edge lands
        // before the first read is offered.
        ST_DRAIN: begin
          cime_q      <= 1'b1;
          oreg_q      <= '0;
          out_valid_q <= 1'b1;
          state_q     <= ST_READ;
        end

        // out_valid drops for one cycle after each accepted word so the
        // offered data always corresponds to the registered cim_oreg.
        ST_READ: begin
          cime_q <= 1'b1;
          if (out_fire) begin
            out_valid_q <= 1'b0;
            if (oreg_q == LAST_BANK) begin
              state_q <= ST_IDLE;
              cime_q  <= 1'b0;
              oreg_q  <= '0;
            end else begin
              oreg_q <= oreg_q + 4'd1;
            end
          end else begin
            out_valid_q <= 1'b1;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = cim_rdata;
  assign out_last     = out_valid_q && (oreg_q == LAST_BANK);
  assign cmd_err      = cmd_err_q;
  assign cim_cs       = cs_q;
  assign cim_we       = we_q;
  assign cim_cime     = cime_q;
  assign cim_psum_e   = psum_q;
  assign cim_rst_oreg = rst_oreg_q;
  assign cim_oreg     = oreg_q;
  assign cim_addr     = addr_q;
  assign cim_wdata    = wdata_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cim_macro_driver.sv
// Bench for cim_macro_driver: a behavioural CIM macro reacts to the bus
// pins, while a command-level reference model predicts the bus cycles and
// bank results. Monitors pop expected entries and compare.
module tb_cim_macro_driver;
  import cim_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_op, cmd_err;
  logic [31:0] cmd_base;
  logic [8:0]  cmd_len;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy;
  logic        cim_cs, cim_we, cim_cime, cim_psum_e, cim_rst_oreg;
  logic [3:0]  cim_oreg;
  logic [31:0] cim_addr, cim_wdata, cim_rdata;
  cim_state_e  dbg_state;

  cim_macro_driver dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy),
    .cim_cs(cim_cs), .cim_we(cim_we), .cim_cime(cim_cime),
    .cim_psum_e(cim_psum_e), .cim_rst_oreg(cim_rst_oreg),
    .cim_oreg(cim_oreg), .cim_addr(cim_addr), .cim_wdata(cim_wdata),
    .cim_rdata(cim_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // ---------------- behavioural macro ----------------
  logic [7:0]  mem [1024];
  int          acc [8];
  logic [31:0] acc_sel;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    for (int b = 0; b < 8; b++) acc[b] = 0;
  end

  function automatic int dot_bank(input int b, input logic [31:0] a, input logic [31:0] d);
    int s = 0;
    for (int j = 0; j < 8; j++)
      s += int'(d[4*j +: 4]) * int'(mem[b*128 + ((int'(a[6:0]) + j) & 127)]);
    return s;
  endfunction

  always @(posedge clk) begin
    if (cim_cs === 1'b1) begin
      if (cim_we === 1'b1)
        for (int i = 0; i < 4; i++)
          mem[(int'(cim_addr[9:0]) + i) & 1023] <= cim_wdata[8*i +: 8];
      if (cim_cime === 1'b1 && cim_rst_oreg === 1'b1) begin
        for (int b = 0; b < 8; b++) acc[b] <= 0;
      end else if (cim_cime === 1'b1 && cim_psum_e === 1'b1) begin
        for (int b = 0; b < 8; b++) acc[b] <= acc[b] + dot_bank(b, cim_addr, cim_wdata);
      end
    end
  end

  assign acc_sel   = acc[cim_oreg[2:0]];
  assign cim_rdata = {{26{acc_sel[13]}}, acc_sel[13:8]};

  // ---------------- reference model ----------------
  logic [7:0]  w [1024];         // weight bytes as the commands intend them
  logic [31:0] mac_in [16];
  logic [31:0] ld_words [256];

  initial for (int i = 0; i < 1024; i++) w[i] = 8'h00;

  function automatic logic [31:0] ref_bank(input int b, input logic [31:0] base, input int n);
    logic [31:0] sum;
    logic [31:0] a;
    sum = 32'd0;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < 8; j++) begin
        a = base + 32'(8*k + j);
        sum += 32'(mac_in[k][4*j +: 4]) * 32'(w[b*128 + int'(a[6:0])]);
      end
    return {{26{sum[13]}}, sum[13:8]};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        care;
    logic        we, cime, psum, rsto;
    logic [31:0] addr, data;
  } bus_t;

  logic [32:0] exp_q[$];   // {last, data}
  bus_t        exp_bus_q[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) fail_now("out_unexpected");
      else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("out_data", out_data, e[31:0]);
        check("out_last", 32'(out_last), 32'(e[32]));
      end
    end
    if (cim_cs === 1'b1) begin
      if (exp_bus_q.size() == 0) fail_now("bus_unexpected_cs");
      else begin
        bus_t e;
        e = exp_bus_q.pop_front();
        check("bus_ctrl", 32'({cim_we, cim_cime, cim_psum_e, cim_rst_oreg}),
              32'({e.we, e.cime, e.psum, e.rsto}));
        if (e.care) begin
          check("bus_addr", cim_addr, e.addr);
          check("bus_wdata", cim_wdata, e.data);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  logic hold_low = 1'b0;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic op, input logic [31:0] base, input logic [8:0] len);
    int t = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) fail_now("cmd_accept_timeout");
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic is_mac,
                           input logic [31:0] addr, input int gap_max);
    int t = 0;
    bus_t e;
    repeat ($urandom_range(0, gap_max)) tick();
    in_valid = 1'b1; in_data = d;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (!in_ready) fail_now("in_ready_timeout");
    @(posedge clk);
    e.care = 1'b1; e.addr = addr; e.data = d;
    e.we = !is_mac; e.cime = is_mac; e.psum = is_mac; e.rsto = 1'b0;
    exp_bus_q.push_back(e);
    #1;
    in_valid = 1'b0; in_data = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while (busy && t < 300) begin @(negedge clk); t++; end
    if (busy) fail_now(name);
    tick();
  endtask

  task automatic run_load(input logic [31:0] base, input int n, input int gap_max);
    logic [31:0] a;
    issue_cmd(OP_LOAD, base, 9'(n));
    for (int k = 0; k < n; k++) begin
      a = base + 32'(4*k);
      send_word(ld_words[k], 1'b0, a, gap_max);
      for (int i = 0; i < 4; i++) w[(int'(a[9:0]) + i) & 1023] = ld_words[k][8*i +: 8];
    end
    @(negedge clk);
    check("load_busy_fall", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic push_clear();
    bus_t e;
    e = '0;
    e.cime = 1'b1; e.rsto = 1'b1;
    exp_bus_q.push_back(e);
  endtask

  task automatic run_mac(input logic [31:0] base, input int n, input logic stall, input int gap_max);
    int t = 0;
    if (stall) begin hold_low = 1'b1; out_ready = 1'b0; end
    issue_cmd(OP_MAC, base, 9'(n));
    push_clear();
    for (int k = 0; k < n; k++) send_word(mac_in[k], 1'b1, base + 32'(8*k), gap_max);
    for (int b = 0; b < 8; b++) exp_q.push_back({(b == 7), ref_bank(b, base, n)});
    if (stall) begin
      @(negedge clk);
      while (!out_valid && t < 20) begin @(negedge clk); t++; end
      if (!out_valid) fail_now("read_valid_timeout");
      for (int c = 0; c < 5; c++) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, exp_q[0][31:0]);
        check("stall_oreg", 32'(cim_oreg), 32'd0);
        @(negedge clk);
      end
      hold_low = 1'b0;
    end
    wait_idle("mac_idle_timeout");
    check("mac_results_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_outs", 32'({out_valid, cmd_err, cim_cs, cim_we, cim_cime, cim_psum_e, cim_rst_oreg, cim_oreg}), 32'd0);
    check("reset_addr", cim_addr, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // LOAD two words of 0x10 bytes at base 0
    ld_words[0] = 32'h1010_1010; ld_words[1] = 32'h1010_1010;
    run_load(32'd0, 2, 0);
    for (int i = 0; i < 8; i++) check("macro_byte", 32'(mem[i]), 32'd16);

    // MAC base 0, one step of all-15 nibbles: bank0 = 7, others 0
    mac_in[0] = 32'hFFFF_FFFF;
    run_mac(32'd0, 1, 1'b0, 0);

    // Two steps: second window is empty, so bank0 stays 7 (clear precedes accumulate)
    mac_in[0] = 32'hFFFF_FFFF; mac_in[1] = 32'h1111_1111;
    run_mac(32'd0, 2, 1'b0, 0);

    // Rejected commands
    issue_cmd(OP_LOAD, 32'd0, 9'd0);
    @(negedge clk);
    check("err_len0_pulse", 32'(cmd_err), 32'd1);
    check("err_len0_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("err_pulse_width", 32'(cmd_err), 32'd0);
    tick();
    issue_cmd(OP_MAC, 32'd0, 9'd17);
    @(negedge clk);
    check("err_mac17_pulse", 32'(cmd_err), 32'd1);
    check("err_mac17_idle", 32'(busy), 32'd0);
    tick();
    issue_cmd(OP_LOAD, 32'd0, 9'd257);
    @(negedge clk);
    check("err_load257_pulse", 32'(cmd_err), 32'd1);
    tick();

    // Output back-pressure during READ, with input gaps during MAC
    for (int k = 0; k < 4; k++) mac_in[k] = $urandom;
    run_mac(32'd0, 4, 1'b1, 3);

    // Reset during MAC step 1 of 3
    for (int k = 0; k < 3; k++) mac_in[k] = $urandom;
    issue_cmd(OP_MAC, 32'd0, 9'd3);
    push_clear();
    send_word(mac_in[0], 1'b1, 32'd0, 0);
    send_word(mac_in[1], 1'b1, 32'd8, 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_cim", 32'({cim_cs, cim_we, cim_cime, cim_psum_e, cim_rst_oreg, cim_oreg}), 32'd0);
    check("rst_mid_addr", cim_addr, 32'd0);
    check("rst_mid_wdata", cim_wdata, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_bus_q", 32'(exp_bus_q.size()), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) mac_in[k] = $urandom;
    run_mac(32'd0, 3, 1'b0, 1);

    // Randomized LOAD/MAC pairs
    for (int it = 0; it < 8; it++) begin
      int n;
      logic [31:0] base;
      n = $urandom_range(1, 24);
      for (int k = 0; k < n; k++) ld_words[k] = $urandom;
      base = $urandom & 32'hFFFF_FFFC;
      run_load(base, n, 2);
      n = (it == 0) ? 16 : $urandom_range(1, 16);
      for (int k = 0; k < n; k++) mac_in[k] = $urandom;
      run_mac($urandom, n, 1'b0, 2);
    end

    repeat (4) tick();
    check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_bus_q_empty", 32'(exp_bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cim_macro_driver.md
Name: cim_macro_driver

Overview:
- Initiator-side sequencer for the 8-bank GeMM CIM macro.
- Takes commands from the core/host: LOAD writes weight words into the macro; MAC clears the accumulators, streams N input vectors and returns the 8 bank results.
- Owns every macro control pin (cs, we, cime, partial-sum enable, output-register reset/select, address, data). The core never touches the macro directly while the driver is attached.

Parameters:
- MAX_STEPS, 16, maximum MAC steps per command (128-byte bank window / 8 bytes per step).
- MAX_WORDS, 256, maximum LOAD words per command (1024-byte array / 4 bytes per word).
- N_BANKS, 8, number of macro output banks / result words per MAC.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  1  0=LOAD, 1=MAC
- cmd_base  in  32  byte address of first word/step
- cmd_len  in  9  LOAD words (1..MAX_WORDS) or MAC steps (1..MAX_STEPS)
- cmd_err  out  1  one-cycle pulse: command rejected
- in_valid / in_ready  in/out  1  input word stream handshake
- in_data  in  32  weight word (LOAD) or 8x4-bit input vector (MAC)
- out_valid / out_ready  out/in  1  result stream handshake
- out_data  out  32  sign-extended 6-bit bank result
- out_last  out  1  high with the bank-7 result
- busy  out  1  state != IDLE
- cim_cs, cim_we, cim_cime, cim_psum_e, cim_rst_oreg  out  1  macro controls
- cim_oreg  out  4  macro output-register select
- cim_addr  out  32  macro address
- cim_wdata  out  32  macro input_data
- cim_rdata  in  32  macro cim_output (combinational from cim_oreg)

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, all cim_* outputs 0, out_valid=0, cmd_err=0, counters 0. Reset mid-command aborts with no further bus cycles; macro accumulators are left untouched.
- All cim_* outputs are registered. A bus cycle is driven the cycle after it is decided.
- States: IDLE, LOAD, CLR, MAC, DRAIN, READ.
- IDLE: on cmd_valid&&cmd_ready, latch base/len/op.
  - len==0 or len above its op limit: pulse cmd_err, stay IDLE.
  - Valid LOAD -> LOAD. Valid MAC -> CLR.
- LOAD: in_ready=1. Each in handshake k drives next cycle cs=1, we=1, cime=0, addr=base+4k, wdata=in_data. After the len-th handshake -> IDLE. No handshake means an idle bus cycle (cs=0).
- CLR: one cycle, in_ready=0. Next cycle drives cs=1, we=0, cime=1, rst_oreg=1, psum_e=0. -> MAC.
- MAC: in_ready=1. Each handshake k drives next cycle cs=1, we=0, cime=1, psum_e=1, rst_oreg=0, addr=base+8k, wdata=in_data. After the len-th handshake -> DRAIN.
- DRAIN: one cycle with cs=0, cime=1. This lets the final accumulate edge land before any read. -> READ.
- READ: cs=0, cime=1, psum_e=0, cim_oreg=idx (registered, starts at 0).
  - out_valid=1, out_data=cim_rdata, out_last=(idx==7).
  - On out_ready, idx increments and cim_oreg updates the next cycle; out_valid drops for that one cycle so data always matches cim_oreg.
  - After idx 7 is accepted -> IDLE, cime returns to 0.
- Step address wrap: base+8k is computed in 32 bits. The macro uses addr[6:0], so only base bits [6:0] are meaningful for MAC; the driver does no range checking.
- cmd_valid while busy is ignored (cmd_ready=0). in_data is never consumed outside LOAD/MAC.
- we and rst_oreg are never high in the same bus cycle. cs=0 in every non-bus cycle.

Decomposition:
- Shared package cim_pkg:
  - state enum
  - op codes OP_LOAD/OP_MAC
  - N_BANKS, MAX_STEPS, MAX_WORDS, CIM_STEP_BYTES=8, WORD_BYTES=4
- No sub-module: a single FSM plus counters and a registered bus-output stage. Estimated 200–300 lines.

Test Plan:
- LOAD base=0 len=2, data 0x10101010 x2 -> exactly two write cycles, addr 0 then 4; macro bytes 0..7 = 16; busy falls 1 cycle after the second handshake.
- After the above, MAC base=0 len=1, in 0xFFFFFFFF -> one clear cycle, one MAC cycle at addr 0, one DRAIN cycle; results 7,0,0,0,0,0,0,0 (8·15·16=1920, bits[13:8]=7), out_last on the 8th word.
- MAC base=0 len=2, inputs 0xFFFFFFFF then 0x11111111 -> MAC addresses 0, 8; bank0 result 7 (bytes 8..15 are zero); proves the clear happens before accumulation.
- cmd_len=0 and MAC cmd_len=17 -> cmd_err pulse, no cim_cs activity, stays IDLE.
- out_ready held low 5 cycles during READ -> out_data stable and equal to bank0, no idx advance; in_valid gaps in MAC -> matching cs=0 bubbles with no address skip.
- rst_n low during MAC step 1 of 3 -> next cycle all cim_* = 0, busy=0; a new MAC command then yields correct results.
